// File: rtl/poly1305_pkg.sv
// Shared definitions for the poly1305 message driver and its core wrapper:
// state encoding, block geometry and byte-lane helpers (first byte in the MSB lane).
package poly1305_pkg;

  localparam int BYTE_W      = 8;
  localparam int WORD_BYTES  = 4;
  localparam int WORD_W      = WORD_BYTES * BYTE_W;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_WORDS = BLOCK_BYTES / WORD_BYTES;
  localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;
  localparam int BLOCKLEN_W  = 5;
  localparam int KEY_W       = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_INIT_WAIT,
    ST_FILL,
    ST_NEXT,
    ST_NEXT_WAIT,
    ST_FIN,
    ST_FIN_WAIT,
    ST_DONE
  } state_e;

  // Bytes carried by an accepted word; out-of-range counts on a last word mean a full word.
  function automatic logic [2:0] word_bytes(input logic last, input logic [2:0] nbytes);
    if (!last || nbytes == 3'd0 || nbytes > 3'd4) return 3'd4;
    return nbytes;
  endfunction

  // Keeps the leading nbytes of a word, zeroing the trailing lanes.
  function automatic logic [WORD_W-1:0] word_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 32'hFF00_0000;
      3'd2:    return 32'hFFFF_0000;
      3'd3:    return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/poly1305_block_packer.sv
// Byte-offset accumulator: packs 32-bit words into a 16-byte block, first byte at the MSB.
module poly1305_block_packer
  import poly1305_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [2:0]            wr_bytes,
  output logic [BLOCK_W-1:0]    block,
  output logic [BLOCKLEN_W-1:0] count_next,
  output logic                  full_next
);

  logic [BLOCK_WORDS-1:0][WORD_W-1:0] words_q;
  logic [BLOCKLEN_W-1:0]              count_q;
  logic [1:0]                         lane;

  // Word boundaries always fall on 4-byte offsets, so the offset selects a whole lane.
  assign lane       = count_q[3:2];
  assign count_next = count_q + BLOCKLEN_W'(wr_bytes);
  assign full_next  = (count_next == BLOCKLEN_W'(BLOCK_BYTES));
  assign block      = words_q;

  // NOTE: block storage is reset too, so a partial block dropped by reset never leaks out.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      words_q <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      words_q[2'(BLOCK_WORDS - 1) - lane] <= wr_data & word_mask(wr_bytes);
      count_q                              <= count_next;
    end
  end

endmodule

// File: rtl/poly1305_msg_driver.sv
// Initiator for the poly1305 core: packs a word stream into blocks and sequences
// init / next / finish, then returns the MAC and an optional tag-compare flag.
module poly1305_msg_driver
  import poly1305_pkg::*;
#(
  parameter bit CMP_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  empty,
  input  logic [KEY_W-1:0]      key,
  input  logic [BLOCK_W-1:0]    exp_tag,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic [2:0]            s_bytes,
  output logic                  s_ready,
  output logic                  core_init,
  output logic                  core_next,
  output logic                  core_finish,
  output logic [KEY_W-1:0]      core_key,
  output logic [BLOCK_W-1:0]    core_block,
  output logic [BLOCKLEN_W-1:0] core_blocklen,
  input  logic                  core_ready,
  input  logic [BLOCK_W-1:0]    core_mac,
  output logic                  busy,
  output logic                  done,
  output logic [BLOCK_W-1:0]    mac,
  output logic                  tag_ok
);

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      key_q;
  logic [BLOCK_W-1:0]    exp_q;
  logic                  empty_q;
  logic                  last_seen_q;
  logic [BLOCKLEN_W-1:0] blocklen_q;
  logic                  start_acc, blk_close, fin_take;
  logic                  pk_clear, pk_wr, pk_full_next;
  logic [BLOCKLEN_W-1:0] pk_count_next;

  poly1305_block_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .wr_en      (pk_wr),
    .wr_data    (s_data),
    .wr_bytes   (word_bytes(s_last, s_bytes)),
    .block      (core_block),
    .count_next (pk_count_next),
    .full_next  (pk_full_next)
  );

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    core_init   = 1'b0;
    core_next   = 1'b0;
    core_finish = 1'b0;
    done        = 1'b0;
    pk_clear    = 1'b0;
    pk_wr       = 1'b0;
    start_acc   = 1'b0;
    blk_close   = 1'b0;
    fin_take    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        start_acc = 1'b1;
        state_d   = ST_INIT;
      end
      ST_INIT: if (core_ready) begin
        core_init = 1'b1;
        state_d   = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (core_ready) begin
        if (empty_q) state_d = ST_FIN;
        else begin
          pk_clear = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          pk_wr = 1'b1;
          if (pk_full_next || s_last) begin
            blk_close = 1'b1;
            state_d   = ST_NEXT;
          end
        end
      end
      ST_NEXT: if (core_ready) begin
        core_next = 1'b1;
        state_d   = ST_NEXT_WAIT;
      end
      ST_NEXT_WAIT: if (core_ready) begin
        if (last_seen_q) state_d = ST_FIN;
        else begin
          pk_clear = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FIN: if (core_ready) begin
        core_finish = 1'b1;
        state_d     = ST_FIN_WAIT;
      end
      ST_FIN_WAIT: if (core_ready) begin
        fin_take = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q       <= '0;
      exp_q       <= '0;
      empty_q     <= 1'b0;
      busy        <= 1'b0;
      last_seen_q <= 1'b0;
      blocklen_q  <= '0;
      mac         <= '0;
      tag_ok      <= 1'b0;
    end else begin
      if (start_acc) begin
        key_q   <= key;
        exp_q   <= exp_tag;
        empty_q <= empty;
        busy    <= 1'b1;
      end
      if (pk_clear) last_seen_q <= 1'b0;
      if (blk_close) begin
        blocklen_q  <= pk_count_next;
        last_seen_q <= s_last;
      end
      if (fin_take) begin
        mac    <= core_mac;
        tag_ok <= CMP_EN && (core_mac == exp_q);
      end
      if (state_q == ST_DONE) busy <= 1'b0;
    end
  end

  assign core_key      = key_q;
  assign core_blocklen = blocklen_q;

endmodule

// File: tb/tb_poly1305_msg_driver.sv
// Directed bench for poly1305_msg_driver with a behavioural Poly1305 core and a block scoreboard.
module tb_poly1305_msg_driver;
  import poly1305_pkg::*;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [BLOCK_W-1:0]    block;
    logic [BLOCKLEN_W-1:0] len;
  } sb_t;

  localparam logic [255:0] RFC_KEY =
    256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b;
  localparam logic [127:0] RFC_MAC = 128'ha8061dc1305136c6c22b8baf0c0127a9;
  localparam logic [127:0] CLAMP   = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [263:0] P1305   = (264'd1 << 130) - 264'd5;
  localparam int           BOUND   = 2000;

  logic                  clk = 1'b0;
  logic                  reset, start, empty;
  logic [KEY_W-1:0]      key;
  logic [BLOCK_W-1:0]    exp_tag;
  logic [WORD_W-1:0]     s_data;
  logic                  s_valid, s_last;
  logic [2:0]            s_bytes;
  logic                  s_ready;
  logic                  core_init, core_next, core_finish;
  logic [KEY_W-1:0]      core_key;
  logic [BLOCK_W-1:0]    core_block;
  logic [BLOCKLEN_W-1:0] core_blocklen;
  logic                  core_ready;
  logic [BLOCK_W-1:0]    core_mac;
  logic                  busy, done;
  logic [BLOCK_W-1:0]    mac;
  logic                  tag_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  poly1305_msg_driver #(.CMP_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .empty(empty), .key(key), .exp_tag(exp_tag),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_bytes(s_bytes), .s_ready(s_ready),
    .core_init(core_init), .core_next(core_next), .core_finish(core_finish),
    .core_key(core_key), .core_block(core_block), .core_blocklen(core_blocklen),
    .core_ready(core_ready), .core_mac(core_mac),
    .busy(busy), .done(done), .mac(mac), .tag_ok(tag_ok)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
    return o;
  endfunction

  // One Poly1305 block step; n_le is the block as a little-endian integer.
  function automatic logic [129:0] poly_step(input logic [129:0] acc, input logic [127:0] r,
                                             input logic [127:0] n_le, input int len);
    logic [263:0] n, t;
    n = {136'd0, n_le} | (264'd1 << (8 * len));
    t = ((264'(acc) + n) * 264'(r)) % P1305;
    return t[129:0];
  endfunction

  function automatic logic [127:0] poly_ref(input logic [255:0] k, input bq_t m);
    logic [127:0] r, s, n;
    logic [129:0] acc;
    int len;
    r   = bswap(k[255:128]) & CLAMP;
    s   = bswap(k[127:0]);
    acc = '0;
    for (int b = 0; b < m.size(); b += 16) begin
      len = (m.size() - b < 16) ? m.size() - b : 16;
      n   = '0;
      for (int j = 0; j < len; j++) n[8*j +: 8] = m[b+j];
      acc = poly_step(acc, r, n, len);
    end
    return bswap(acc[127:0] + s);
  endfunction

  // Behavioural core: ready drops for lat_min..lat_max cycles after every command.
  sb_t          sb_q[$];
  int           lat_min = 1, lat_max = 1;
  int           busy_cnt = 0;
  logic [127:0] m_r, m_s;
  logic [129:0] m_acc;

  assign core_ready = (busy_cnt == 0);

  always @(posedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
      core_mac <= '0;
      m_acc    <= '0;
    end else begin
      if (core_init || core_next || core_finish) busy_cnt <= $urandom_range(lat_max, lat_min);
      else if (busy_cnt != 0)                    busy_cnt <= busy_cnt - 1;
      if (core_init) begin
        m_r   <= bswap(core_key[255:128]) & CLAMP;
        m_s   <= bswap(core_key[127:0]);
        m_acc <= '0;
      end
      if (core_next) begin
        if (sb_q.size() == 0) check("next_unexpected", 256'(core_blocklen), 256'(0));
        else begin
          check("blk_data", 256'(core_block), 256'(sb_q[0].block));
          check("blk_len", 256'(core_blocklen), 256'(sb_q[0].len));
          sb_q.delete(0);
        end
        m_acc <= poly_step(m_acc, m_r, bswap(core_block), int'(core_blocklen));
      end
      if (core_finish) core_mac <= bswap(m_acc[127:0] + m_s);
    end
  end

  // Protocol monitor: pulse counts, overlap and width violations.
  int   n_init = 0, n_next = 0, n_fin = 0, n_done = 0, n_srdy = 0, n_viol = 0;
  logic p_init = 1'b0, p_next = 1'b0, p_fin = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      n_init <= n_init + int'(core_init);
      n_next <= n_next + int'(core_next);
      n_fin  <= n_fin + int'(core_finish);
      n_done <= n_done + int'(done);
      n_srdy <= n_srdy + int'(s_ready);
      if ((int'(core_init) + int'(core_next) + int'(core_finish) > 1) ||
          (core_init && p_init) || (core_next && p_next) || (core_finish && p_fin))
        n_viol <= n_viol + 1;
    end
    p_init <= core_init;
    p_next <= core_next;
    p_fin  <= core_finish;
  end

  task automatic push_blocks(input bq_t m);
    sb_t e;
    int  len;
    for (int b = 0; b < m.size(); b += 16) begin
      len     = (m.size() - b < 16) ? m.size() - b : 16;
      e.block = '0;
      for (int j = 0; j < len; j++) e.block[127-8*j -: 8] = m[b+j];
      e.len = BLOCKLEN_W'(len);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [255:0] k, input logic [127:0] t, input logic e);
    @(negedge clk);
    start = 1'b1; key = k; exp_tag = t; empty = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives up to max_words words of m; returns at a negedge after the last acceptance.
  task automatic drive_msg(input bq_t m, input bit gaps, input int max_words);
    int nw, nb, cnt;
    logic [31:0] d;
    nw = (m.size() + 3) / 4;
    for (int w = 0; w < nw && w < max_words; w++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      nb = (m.size() - 4*w < 4) ? m.size() - 4*w : 4;
      d  = '0;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = m[4*w+b];
      s_data = d; s_valid = 1'b1; s_last = (w == nw - 1); s_bytes = 3'(nb);
      cnt = 0;
      while (!s_ready && cnt < BOUND) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= BOUND) begin
        check("s_ready_timeout", 256'(0), 256'(1));
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done();
    int cnt = 0;
    while (!done && cnt < BOUND) begin
      @(negedge clk);
      cnt++;
    end
    check("done_seen", 256'(done), 256'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 256'({s_ready, core_init, core_next, core_finish, busy, done, tag_ok,
                                core_blocklen}), 256'(0));
    check({tag, "_key"}, core_key, 256'(0));
    check({tag, "_blk"}, 256'(core_block), 256'(0));
    check({tag, "_mac"}, 256'(mac), 256'(0));
    check({tag, "_state"}, 256'(dut.state_q), 256'(ST_IDLE));
  endtask

  bq_t          rfc, rnd;
  string        str;
  logic [127:0] key_s, exp_rnd;
  int           s_init, s_next, s_fin, s_done, s_srdy;

  task automatic snap();
    s_init = n_init; s_next = n_next; s_fin = n_fin; s_done = n_done; s_srdy = n_srdy;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; empty = 1'b0; key = '0; exp_tag = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_bytes = '0;
    str = "Cryptographic Forum Research Group";
    for (int i = 0; i < str.len(); i++) rfc.push_back(str[i]);
    for (int i = 0; i < 32; i++) rnd.push_back(8'($urandom));
    key_s   = RFC_KEY[127:0];
    exp_rnd = poly_ref(RFC_KEY, rnd);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // RFC vector, matching tag
    push_blocks(rfc); snap();
    do_start(RFC_KEY, RFC_MAC, 1'b0);
    drive_msg(rfc, 1'b0, 99);
    wait_done();
    check("rfc_mac", 256'(mac), 256'(RFC_MAC));
    check("rfc_tag_ok", 256'(tag_ok), 256'(1));
    @(negedge clk);
    check("rfc_nexts", 256'(n_next - s_next), 256'(3));
    check("rfc_busy_after", 256'(busy), 256'(0));

    // Flipped tag plus a start pulse while busy
    push_blocks(rfc); snap();
    do_start(RFC_KEY, RFC_MAC ^ 128'd1, 1'b0);
    start = 1'b1; key = ~RFC_KEY; empty = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during", 256'(busy), 256'(1));
    drive_msg(rfc, 1'b0, 99);
    wait_done();
    check("flip_mac", 256'(mac), 256'(RFC_MAC));
    check("flip_tag_ok", 256'(tag_ok), 256'(0));
    check("flip_key_held", core_key, RFC_KEY);
    @(negedge clk);
    check("flip_inits", 256'(n_init - s_init), 256'(1));
    check("flip_dones", 256'(n_done - s_done), 256'(1));

    // Empty message
    snap();
    do_start(RFC_KEY, key_s, 1'b1);
    wait_done();
    check("empty_mac", 256'(mac), 256'(key_s));
    check("empty_tag_ok", 256'(tag_ok), 256'(1));
    @(negedge clk);
    check("empty_inits", 256'(n_init - s_init), 256'(1));
    check("empty_nexts", 256'(n_next - s_next), 256'(0));
    check("empty_fins", 256'(n_fin - s_fin), 256'(1));
    check("empty_sready", 256'(n_srdy - s_srdy), 256'(0));

    // 32 random bytes, stream gaps, slow core
    lat_min = 5; lat_max = 40;
    push_blocks(rnd); snap();
    do_start(RFC_KEY, exp_rnd, 1'b0);
    drive_msg(rnd, 1'b1, 99);
    wait_done();
    check("rnd_mac", 256'(mac), 256'(exp_rnd));
    check("rnd_tag_ok", 256'(tag_ok), 256'(1));
    @(negedge clk);
    check("rnd_nexts", 256'(n_next - s_next), 256'(2));
    check("rnd_sb_empty", 256'(sb_q.size()), 256'(0));
    lat_min = 1; lat_max = 1;

    // Reset in the middle of FILL after three words
    do_start(RFC_KEY, RFC_MAC, 1'b0);
    drive_msg(rfc, 1'b0, 3);
    check("mid_fill_state", 256'(dut.state_q), 256'(ST_FILL));
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    sb_q.delete();

    // Full RFC run after the reset
    push_blocks(rfc); snap();
    do_start(RFC_KEY, RFC_MAC, 1'b0);
    drive_msg(rfc, 1'b0, 99);
    wait_done();
    check("post_rst_mac", 256'(mac), 256'(RFC_MAC));
    check("post_rst_tag_ok", 256'(tag_ok), 256'(1));
    @(negedge clk);
    check("post_rst_sb_empty", 256'(sb_q.size()), 256'(0));
    check("cmd_pulse_violations", 256'(n_viol), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly1305_msg_driver.md
Name: poly1305_msg_driver

Overview:
- Initiator side of the poly1305 core command interface (init/next/finish/ready, key, block, blocklen, mac).
- Accepts a key, an optional expected tag, and a 32-bit word stream with valid/ready.
- Packs the stream into 16-byte blocks and sequences the core through init, next and finish.
- Returns the MAC and a tag-compare flag; sits between the bus-facing AEAD wrapper and the core.

Parameters:
- CMP_EN, 1, 1 = compute tag_ok against exp_tag; 0 = tag_ok tied 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- empty  in  1  sampled with start; 1 = zero-length message, no words consumed
- key  in  256  one-time key; key[255:248] = first key byte
- exp_tag  in  128  expected tag; [127:120] = first tag byte
- s_data  in  32  message word; first byte in [31:24]
- s_valid  in  1  word valid
- s_last  in  1  final word of message
- s_bytes  in  3  valid bytes in a last word (1..4); ignored when s_last=0
- s_ready  out  1  word accepted when s_valid & s_ready
- core_init / core_next / core_finish  out  1 each  one-cycle command pulses
- core_key  out  256  registered copy of key
- core_block  out  128  packed block; first byte at [127:120]; unused bytes zero
- core_blocklen  out  5  1..16; never 0
- core_ready  in  1  core ready
- core_mac  in  128  core MAC
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse when mac/tag_ok valid
- mac  out  128  registered MAC, held until next start
- tag_ok  out  1  mac == exp_tag, held until next start

Behaviour:
- Reset values: all outputs 0; state IDLE; internal byte count 0; last_seen 0.
- States: IDLE, INIT, INIT_WAIT, FILL, NEXT, NEXT_WAIT, FIN, FIN_WAIT, DONE.
- IDLE: on start, register key, exp_tag and empty; set busy; go to INIT. Start in any other state is ignored.
- INIT: wait for core_ready=1; in that cycle pulse core_init; go to INIT_WAIT.
- INIT_WAIT: stay while core_ready=0 (guaranteed low the cycle after a command). On core_ready=1: if empty, go to FIN; else clear the block and count and go to FILL.
- FILL: s_ready=1.
  - Each accepted word writes 4 bytes, or s_bytes on a last word, at byte offset count.
  - count increments by that amount.
  - If count reaches 16, or s_last is accepted: latch blocklen = count (16 encoded as 5'h10), set last_seen = s_last, go to NEXT.
  - Word boundaries always align with 4-byte offsets. A partial word is legal only as the last word.
  - s_bytes of 0 or >4 on a last word is treated as 4.
- NEXT: wait for core_ready; pulse core_next with core_block/core_blocklen stable; go to NEXT_WAIT.
- NEXT_WAIT: on core_ready=1, go to FIN if last_seen, else go to FILL with count cleared and block zeroed.
- FIN: wait for core_ready; pulse core_finish; go to FIN_WAIT.
- FIN_WAIT: on core_ready=1, register mac = core_mac and tag_ok = CMP_EN & (core_mac == exp_tag); go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- core_block and core_blocklen are registered and held stable from the NEXT cycle until the next FILL.
- Command pulses are mutually exclusive and never two cycles wide.
- Exactly 16-byte multiples: the final full block is issued as blocklen 16; no extra empty block is issued.
- s_ready is 0 in every state except FILL, so backpressure holds the stream during core processing.
- Reset mid-operation: return to IDLE in one cycle and drop any partial block. The parent resets the core on the same edge.

Decomposition:
- Shared package poly1305_pkg:
  - state enum;
  - BLOCK_BYTES=16 and BLOCKLEN_W=5;
  - byte-order helper constants shared with the core wrapper.
- One sub-module, poly1305_block_packer: byte-offset accumulator with clear, write-word (data, nbytes) and full/count outputs.
- The FSM stays in poly1305_msg_driver.

Test Plan:
- Message and key:
  - key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b;
  - message "Cryptographic Forum Research Group" (34 bytes, 9 words, last s_bytes=2).
- Response: blocklens 16,16,2; mac a8061dc1305136c6c22b8baf0c0127a9; tag_ok=1 with matching exp_tag.
- Same run with exp_tag bit 0 flipped -> identical mac, tag_ok=0, done pulses once.
- empty=1 start -> core_init, then core_finish, zero core_next pulses, s_ready never high; mac equals s half of key (r·0 + s).
- 32-byte message with random s_valid gaps and the core model holding core_ready low for 5 to 40 cycles -> exactly two next pulses, both blocklen 16, no dropped or duplicated words.
- Reset asserted mid-FILL after 3 words -> next cycle all outputs 0, state IDLE. A following full RFC run passes.
- start pulsed while busy -> ignored; no second init; key register unchanged.
